sec_encode_stage: RTL

Pipelined single-error-correcting (SEC) check-bit generator that sits directly upstream of the 32-bit SEC correction stage. It accepts 32-bit data words over a valid/ready handshake and computes the 8 check bits of the team's (40,32) code. It emits a 41-bit frame: data, check bits and check-enable, which the correction stage consumes unchanged. A two-entry output buffer decouples producer and consumer. A saturating counter records completed frames.

---
 rtl/sec_encode_stage_if.sv | 23 ++
 rtl/sec_encode_stage.sv | 117 +++++++++++
 2 files changed

// File: rtl/sec_encode_stage_if.sv
// Stream bundle for sec_encode_stage: 32-bit word input, 41-bit encoded frame output.
// master = producer/consumer side (testbench or neighbouring stages), slave = encoder.
interface sec_encode_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_bypass;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_chk;
    logic        out_en;

    modport master (
        output in_valid, in_data, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, out_chk, out_en
    );

    modport slave (
        input  in_valid, in_data, in_bypass, out_ready,
        output in_ready, out_valid, out_data, out_chk, out_en
    );
endinterface

// File: rtl/sec_encode_stage.sv
// (40,32) SEC check-bit generator with a 2-entry output FIFO and saturating frame counter.
// Optional one-shot error injection is enabled by defining SEC_ENC_INJECT_EN.
module sec_encode_stage (
    input  logic                 clk,
    input  logic                 rst,
    sec_encode_stage_if.slave    bus,
    output logic [15:0]          frame_cnt
`ifdef SEC_ENC_INJECT_EN
    ,
    input  logic                 inj_arm,
    input  logic [5:0]           inj_bit
`endif
);

    // One 32-bit mask per check bit; c[k] is the parity of the masked data.
    localparam logic [7:0][31:0] CHK_MASK = {
        32'h8888_F0F0,
        32'h4444_0F0F,
        32'h2222_FF00,
        32'h1111_00FF,
        32'hF0F0_8888,
        32'h0F0F_4444,
        32'hFF00_2222,
        32'h00FF_1111
    };

    logic [40:0] entry [2];
    logic        head_ptr;
    logic        tail_ptr;
    logic [1:0]  count;
    logic [7:0]  chk_new;
    logic [39:0] flip;
    logic [40:0] frame_new;
    logic        push;
    logic        pop;
    logic [40:0] head;

    always_comb begin
        chk_new = '0;
        for (int k = 0; k < 8; k++) begin
            chk_new[k] = ^(bus.in_data & CHK_MASK[k]);
        end
    end

`ifdef SEC_ENC_INJECT_EN
    logic       inj_armed;
    logic [5:0] inj_sel;
    logic       inj_go;
    logic [5:0] inj_pos;

    // An arm request in the same cycle as an accept applies to that word.
    always_comb begin
        inj_go  = inj_armed | inj_arm;
        inj_pos = inj_arm ? inj_bit : inj_sel;
        flip    = '0;
        if (inj_go && (inj_pos < 6'd40)) begin
            flip = 40'd1 << inj_pos;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_armed <= 1'b0;
            inj_sel   <= '0;
        end else if (push && inj_go) begin
            inj_armed <= 1'b0;
        end else if (inj_arm) begin
            inj_armed <= 1'b1;
            inj_sel   <= inj_bit;
        end
    end
`else
    always_comb begin
        flip = '0;
    end
`endif

    assign frame_new = {!bus.in_bypass, {chk_new, bus.in_data} ^ flip};

    assign bus.in_ready = !rst && (count < 2'd2);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = !rst && bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry[0]  <= '0;
            entry[1]  <= '0;
            head_ptr  <= 1'b0;
            tail_ptr  <= 1'b0;
            count     <= '0;
            frame_cnt <= '0;
        end else begin
            if (push) begin
                entry[tail_ptr] <= frame_new;
                tail_ptr        <= ~tail_ptr;
            end
            if (pop) begin
                head_ptr <= ~head_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (pop && (frame_cnt != 16'hFFFF)) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign head          = entry[head_ptr];
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = head[31:0];
    assign bus.out_chk   = head[39:32];
    assign bus.out_en    = head[40];

endmodule
